tff_count_ctrl: RTL and testbench
=================================

# tff_count_ctrl

Sequencing controller for a bank of WIDTH toggle flip-flops. Each cycle it generates the per-bit toggle vector that turns the bank into a synchronous up/down counter with parallel load, terminal-count detect, pause and wrap control. The bank itself (q <= q ^ tog) is held inside this block, so the block is self-contained. Upstream logic drives start/stop/load; downstream logic consumes q, busy and done.

## Interface
- WIDTH, 4, number of T flip-flops in the bank (≥2)
- clk  input  1  rising-edge clock, sole clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  begin/resume counting (level sampled at clk edge)
- stop  input  1  pause from RUN; abort from HOLD
- load  input  1  parallel load request
- load_val  input  WIDTH  value loaded when load=1
- dir  input  1  1 = count up, 0 = count down
- term  input  WIDTH  terminal count
- wrap  input  1  1 = keep counting past term, 0 = stop at term
- q  output  WIDTH  flip-flop bank state
- tog  output  WIDTH  combinational toggle vector applied at next edge
- busy  output  1  registered, 1 when FSM ≠ IDLE
- done  output  1  registered one-cycle pulse after term reached

## Operation
- Bank update every edge: q <= q ^ tog. tog is the only path that changes q, including loads.
- FSM states: IDLE, RUN, HOLD. Encoding is free. busy = (state ≠ IDLE).
- Command priority in every state: load > stop > start.
- Toggle generation:
  - load=1: tog = q ^ load_val. State unchanged. Term check suppressed this cycle.
  - RUN, up: tog[0]=1; tog[i] = &q[i-1:0].
  - RUN, down: tog[0]=1; tog[i] = ~|q[i-1:0].
  - IDLE, HOLD, or RUN with (q==term and wrap=0): tog = 0.
- Transitions:
  - IDLE: stop → IDLE; start → RUN.
  - RUN: stop → HOLD; q==term and wrap=0 → IDLE; otherwise stay RUN. start is ignored.
  - HOLD: stop → IDLE; start → RUN.
- done: set for one cycle after any edge sampled in RUN with q==term and load=0. This applies for both wrap=0 and wrap=1.
- Wrap-around is natural:
  - up: all-ones → 0.
  - down: 0 → all-ones.
  - No done unless term equals the value reached.
- dir may change while in RUN; it takes effect on the same cycle's tog.
- Simultaneous start+stop: stop wins. Simultaneous load+start in IDLE: load only; state stays IDLE.

## Timing
- reset low: asynchronously q=0, state=IDLE, busy=0, done=0. tog is forced to 0 while reset is low.
- Reset release: first active edge is the first edge with reset high.
- Start latency: start sampled at edge k → busy=1 after edge k. First count toggle lands at edge k+1.
- Term stop (wrap=0): q==term visible after edge n → edge n+1 leaves q unchanged, state IDLE, done=1 for exactly the cycle after edge n+1.
- Load latency: q = load_val one edge after load is sampled, in any state.
- Reset asserted mid-RUN: all outputs go to reset values without waiting for clk. No pending done survives reset.

## Test plan
- Up count to term, wrap=0: reset, WIDTH=4, q=0, term=3, dir=1, start pulse at edge 1.
  - q reads 1, 2, 3 after edges 2, 3, 4.
  - busy drops and done=1 after edge 5.
  - q holds 3.
- Down with wrap, wrap=1: dir=0, term=14, start from q=0.
  - q goes 15, then 14 with done pulse one cycle later, then 13.
  - busy stays 1; tog after the q=15 edge equals 4'b0001.
- Pause/resume/abort:
  - stop at q=5 → HOLD; q stays 5 and busy=1 for 3 cycles.
  - start → counting resumes at 6.
  - stop in HOLD → IDLE, busy=0, no done.
- Load priority: in RUN at q=9, assert load=1, load_val=2, stop=1 together.
  - Next q=2, state stays RUN, no done even if term=9.
  - Counting continues 3, 4.
- Async reset mid-run: drop reset between edges at q=7.
  - q=0, busy=0, done=0, tog=0 immediately.
  - After release, q stays 0 until a new start.
- Simultaneous start+stop in IDLE: state stays IDLE, busy=0, q unchanged for 4 cycles.

Source files
------------

// File: rtl/tff_count_ctrl.sv
// Toggle flip-flop bank with its sequencing controller: up/down count,
// parallel load, terminal-count detect, pause/resume and wrap control.
module tff_count_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic [WIDTH-1:0] term,
  input  logic             wrap,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] tog,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] cnt_tog;
  logic             at_term;
  logic             halt;
  logic             done_n;
  logic             up_c;
  logic             dn_c;

  assign at_term = (q == term);
  assign halt    = at_term && !wrap;

  // Ripple-carry style toggle terms of a synchronous T-FF counter.
  always_comb begin
    cnt_tog    = '0;
    cnt_tog[0] = 1'b1;
    up_c       = 1'b1;
    dn_c       = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      up_c       = up_c & q[i-1];
      dn_c       = dn_c & ~q[i-1];
      cnt_tog[i] = dir ? up_c : dn_c;
    end
  end

  always_comb begin
    tog = '0;
    if (!reset)
      tog = '0;
    else if (load)
      tog = q ^ load_val;
    else if (state == RUN && !halt)
      tog = cnt_tog;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (load)       state_n = IDLE;
        else if (stop)  state_n = IDLE;
        else if (start) state_n = RUN;
      end
      RUN: begin
        if (load)       state_n = RUN;
        else if (stop)  state_n = HOLD;
        else if (halt)  state_n = IDLE;
      end
      HOLD: begin
        if (load)       state_n = HOLD;
        else if (stop)  state_n = IDLE;
        else if (start) state_n = RUN;
      end
      default: state_n = IDLE;
    endcase
  end

  assign done_n = (state == RUN) && at_term && !load;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      q     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      q     <= q ^ tog;
      busy  <= (state_n != IDLE);
      done  <= done_n;
    end
  end

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Directed bench for tff_count_ctrl: expected q/busy/done are queued
// as each step is driven and popped after the edge that produces them.
module tb_tff_count_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, stop, load, dir, wrap;
  logic [3:0] load_val, term;
  logic [3:0] q, tog;
  logic       busy, done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [3:0] q;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];

  tff_count_ctrl #(.WIDTH(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .stop    (stop),
    .load    (load),
    .load_val(load_val),
    .dir     (dir),
    .term    (term),
    .wrap    (wrap),
    .q       (q),
    .tog     (tog),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic st, input logic sp, input logic ld,
                      input logic [3:0] lv, input logic [3:0] eq,
                      input logic eb, input logic ed, input string tag);
    exp_t e;
    start    = st;
    stop     = sp;
    load     = ld;
    load_val = lv;
    e.tag    = tag;
    e.q      = eq;
    e.busy   = eb;
    e.done   = ed;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".q"}, {4'h0, q}, {4'h0, e.q});
    chk({e.tag, ".busy"}, {7'h0, busy}, {7'h0, e.busy});
    chk({e.tag, ".done"}, {7'h0, done}, {7'h0, e.done});
  endtask

  initial begin
    reset = 1'b0;
    {start, stop, load, dir, wrap} = '0;
    load_val = 4'h0;
    term     = 4'h3;
    #3;
    chk("rst.q", {4'h0, q}, 8'h00);
    chk("rst.busy", {7'h0, busy}, 8'h00);
    chk("rst.done", {7'h0, done}, 8'h00);
    chk("rst.tog", {4'h0, tog}, 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // up to term=3, stop there
    dir = 1'b1; wrap = 1'b0; term = 4'h3;
    step(1, 0, 0, 0, 4'h0, 1, 0, "up.start");
    step(0, 0, 0, 0, 4'h1, 1, 0, "up.e2");
    step(0, 0, 0, 0, 4'h2, 1, 0, "up.e3");
    step(0, 0, 0, 0, 4'h3, 1, 0, "up.e4");
    step(0, 0, 0, 0, 4'h3, 0, 1, "up.term");
    step(0, 0, 0, 0, 4'h3, 0, 0, "up.hold");

    // down with wrap through 0 -> 15 -> 14(term)
    step(0, 0, 1, 4'h0, 4'h0, 0, 0, "dn.load0");
    dir = 1'b0; wrap = 1'b1; term = 4'he;
    step(1, 0, 0, 0, 4'h0, 1, 0, "dn.start");
    step(0, 0, 0, 0, 4'hf, 1, 0, "dn.wrap");
    chk("dn.tog15", {4'h0, tog}, 8'h01);
    step(0, 0, 0, 0, 4'he, 1, 0, "dn.e14");
    step(0, 0, 0, 0, 4'hd, 1, 1, "dn.done");
    step(0, 0, 0, 0, 4'hc, 1, 0, "dn.e12");
    step(0, 1, 0, 0, 4'hb, 1, 0, "dn.stop");

    // pause / resume / abort
    step(0, 0, 1, 4'h4, 4'h4, 1, 0, "pr.ldhold");
    dir = 1'b1; term = 4'hf;
    step(1, 0, 0, 0, 4'h4, 1, 0, "pr.run");
    step(0, 1, 0, 0, 4'h5, 1, 0, "pr.stop5");
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 0, 4'h5, 1, 0, "pr.held");
    step(1, 0, 0, 0, 4'h5, 1, 0, "pr.resume");
    step(0, 0, 0, 0, 4'h6, 1, 0, "pr.e6");
    step(0, 0, 0, 0, 4'h7, 1, 0, "pr.e7");
    step(0, 1, 0, 0, 4'h8, 1, 0, "pr.stop8");
    step(0, 1, 0, 0, 4'h8, 0, 0, "pr.abort");
    step(0, 0, 0, 0, 4'h8, 0, 0, "pr.idle");

    // load beats stop and term in RUN
    step(1, 0, 1, 4'h9, 4'h9, 0, 0, "lp.ldstart");
    wrap = 1'b0; term = 4'h9;
    step(1, 0, 0, 0, 4'h9, 1, 0, "lp.start");
    step(0, 1, 1, 4'h2, 4'h2, 1, 0, "lp.ldstop");
    step(0, 0, 0, 0, 4'h3, 1, 0, "lp.e3");
    step(0, 0, 0, 0, 4'h4, 1, 0, "lp.e4");

    // async reset with a done about to fire
    wrap = 1'b1; term = 4'h7;
    step(0, 0, 0, 0, 4'h5, 1, 0, "ar.e5");
    step(0, 0, 0, 0, 4'h6, 1, 0, "ar.e6");
    step(0, 0, 0, 0, 4'h7, 1, 0, "ar.e7");
    #2;
    reset = 1'b0;
    #1;
    chk("ar.q", {4'h0, q}, 8'h00);
    chk("ar.busy", {7'h0, busy}, 8'h00);
    chk("ar.done", {7'h0, done}, 8'h00);
    chk("ar.tog", {4'h0, tog}, 8'h00);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 0, 4'h0, 0, 0, "ar.post");

    // start+stop together in IDLE
    for (int i = 0; i < 4; i++)
      step(1, 1, 0, 0, 4'h0, 0, 0, "ss.idle");

    chk("sb.empty", {7'h0, sb.size() == 0}, 8'h01);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
